// File: rtl/tour_length_seq.sv
// Sequential closed-tour length evaluator: walks a route through an external
// coordinate table, one leg at a time, summing integer Euclidean distances.
module tour_length_seq #(
  parameter int SIZE       = 8,
  parameter int NUM_CITIES = 5,
  parameter int IDX_W      = 3,
  parameter int LEN_W      = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [NUM_CITIES*IDX_W-1:0] route,
  output logic [IDX_W-1:0]            coord_addr,
  input  logic [SIZE-1:0]             coord_x,
  input  logic [SIZE-1:0]             coord_y,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [LEN_W-1:0]            tour_len
);

  localparam int D_W  = 2 * SIZE + 1;
  // One spare bit so the final square (root+1)^2 never wraps past d.
  localparam int SQ_W = 2 * SIZE + 2;
  localparam int DL_W = SIZE + 3;
  localparam int R_W  = SIZE + 1;
  localparam int RT_W = NUM_CITIES * IDX_W;

  localparam logic [IDX_W-1:0] LAST_LEG = IDX_W'(NUM_CITIES - 1);
  localparam logic [IDX_W:0]   N_CITIES = (IDX_W + 1)'(NUM_CITIES);

  typedef enum logic [2:0] {
    StIdle,
    StFetchA,
    StFetchB,
    StDiff,
    StRoot,
    StAccum,
    StDone
  } state_t;

  state_t            r_state;
  state_t            w_state_d;

  logic [RT_W-1:0]   r_route;
  logic [IDX_W-1:0]  r_leg;
  logic [LEN_W-1:0]  r_acc;
  logic [SIZE-1:0]   r_x1;
  logic [SIZE-1:0]   r_y1;
  logic [SIZE-1:0]   r_x2;
  logic [SIZE-1:0]   r_y2;
  logic [D_W-1:0]    r_d;
  logic [SQ_W-1:0]   r_sq;
  logic [DL_W-1:0]   r_dl;
  logic              r_err;
  logic [LEN_W-1:0]  r_tour_len;

  logic [IDX_W-1:0]  w_leg_next;
  logic [IDX_W-1:0]  w_idx_a;
  logic [IDX_W-1:0]  w_idx_b;
  logic [IDX_W-1:0]  w_idx;
  logic              w_bad;
  logic              w_last;
  logic [SIZE-1:0]   w_dx;
  logic [SIZE-1:0]   w_dy;
  logic [2*SIZE-1:0] w_dx_e;
  logic [2*SIZE-1:0] w_dy_e;
  logic [2*SIZE-1:0] w_dx2;
  logic [2*SIZE-1:0] w_dy2;
  logic [D_W-1:0]    w_d;
  logic              w_sq_gt;
  logic [R_W-1:0]    w_root;
  logic [LEN_W-1:0]  w_acc_sum;

  // Leg indexing: the closing leg wraps back to route position 0.
  assign w_last     = (r_leg == LAST_LEG);
  assign w_leg_next = w_last ? '0 : r_leg + IDX_W'(1);
  assign w_idx_a    = r_route[r_leg*IDX_W +: IDX_W];
  assign w_idx_b    = r_route[w_leg_next*IDX_W +: IDX_W];
  assign w_idx      = (r_state == StFetchB) ? w_idx_b : w_idx_a;
  assign w_bad      = ({1'b0, w_idx} >= N_CITIES);

  assign w_dx   = (r_x1 > r_x2) ? (r_x1 - r_x2) : (r_x2 - r_x1);
  assign w_dy   = (r_y1 > r_y2) ? (r_y1 - r_y2) : (r_y2 - r_y1);
  assign w_dx_e = {{SIZE{1'b0}}, w_dx};
  assign w_dy_e = {{SIZE{1'b0}}, w_dy};
  assign w_dx2  = w_dx_e * w_dx_e;
  assign w_dy2  = w_dy_e * w_dy_e;
  assign w_d    = {1'b0, w_dx2} + {1'b0, w_dy2};

  // Odd-number square walk: sq tracks (n+1)^2 and dl = 2n+3, so root = dl/2 - 1.
  assign w_sq_gt   = (r_sq > {1'b0, r_d});
  assign w_root    = R_W'((r_dl >> 1) - DL_W'(1));
  assign w_acc_sum = r_acc + LEN_W'(w_root);

  assign err      = r_err;
  assign tour_len = r_tour_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    coord_addr = '0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (r_state)
      StIdle: begin
        busy = 1'b0;
        if (start) w_state_d = StFetchA;
      end
      StFetchA: begin
        coord_addr = w_idx_a;
        w_state_d  = w_bad ? StDone : StFetchB;
      end
      StFetchB: begin
        coord_addr = w_idx_b;
        w_state_d  = w_bad ? StDone : StDiff;
      end
      StDiff: w_state_d = StRoot;
      StRoot: begin
        if (w_sq_gt) w_state_d = StAccum;
      end
      StAccum: w_state_d = w_last ? StDone : StFetchA;
      StDone: begin
        done      = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_route    <= '0;
      r_leg      <= '0;
      r_acc      <= '0;
      r_x1       <= '0;
      r_y1       <= '0;
      r_x2       <= '0;
      r_y2       <= '0;
      r_d        <= '0;
      r_sq       <= '0;
      r_dl       <= '0;
      r_err      <= 1'b0;
      r_tour_len <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_route <= route;
            r_acc   <= '0;
            r_leg   <= '0;
          end
        end
        StFetchA: begin
          r_x1 <= coord_x;
          r_y1 <= coord_y;
          if (w_bad) begin
            r_err      <= 1'b1;
            r_tour_len <= '1;
          end
        end
        StFetchB: begin
          r_x2 <= coord_x;
          r_y2 <= coord_y;
          if (w_bad) begin
            r_err      <= 1'b1;
            r_tour_len <= '1;
          end
        end
        StDiff: begin
          r_d  <= w_d;
          r_sq <= SQ_W'(1);
          r_dl <= DL_W'(3);
        end
        StRoot: begin
          if (!w_sq_gt) begin
            r_sq <= r_sq + SQ_W'(r_dl);
            r_dl <= r_dl + DL_W'(2);
          end
        end
        StAccum: begin
          r_acc <= w_acc_sum;
          if (w_last) begin
            // Results are published on the edge that enters DONE.
            r_tour_len <= w_acc_sum;
            r_err      <= 1'b0;
          end else begin
            r_leg <= w_leg_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tour_length_seq.sv
// Self-checking bench for tour_length_seq: directed table, reset/abort and
// mid-run disturbance sequences, then random routes against an arithmetic model.
module tb_tour_length_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [14:0] route = '0;
  logic [2:0]  coord_addr;
  logic [7:0]  coord_x;
  logic [7:0]  coord_y;
  logic        busy;
  logic        done;
  logic        err;
  logic [11:0] tour_len;

  logic [7:0] cx [8];
  logic [7:0] cy [8];

  int checks = 0;
  int errors = 0;

  tour_length_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .route      (route),
    .coord_addr (coord_addr),
    .coord_x    (coord_x),
    .coord_y    (coord_y),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .tour_len   (tour_len)
  );

  always #5 clk = ~clk;

  always_comb begin
    coord_x = cx[coord_addr];
    coord_y = cy[coord_addr];
  end

  typedef struct {
    logic [63:0] xs;
    logic [63:0] ys;
    logic [14:0] rt;
    int          len;
    bit          e;
    int          cyc;
    bit          chk7;
    string       nm;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [14:0] mk_rt(input int a, input int b, input int c, input int d,
                                        input int e);
    return {3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  function automatic logic [63:0] pk(input int c0, input int c1, input int c2, input int c3,
                                     input int c4);
    return {24'd0, 8'(c4), 8'(c3), 8'(c2), 8'(c1), 8'(c0)};
  endfunction

  task automatic set_coords(input logic [63:0] xs, input logic [63:0] ys);
    for (int i = 0; i < 8; i++) begin
      cx[i] = xs[i*8 +: 8];
      cy[i] = ys[i*8 +: 8];
    end
  endtask

  function automatic int isqrt(input int d);
    int r = 0;
    while ((r + 1) * (r + 1) <= d) r++;
    return r;
  endfunction

  // Reference: tour length, error flag and the cycle (after start edge) that shows done.
  task automatic model(input logic [14:0] rt, output int len, output bit e, output int cyc);
    int a, b, dx, dy;
    len = 0; e = 1'b0; cyc = 0;
    for (int k = 0; k < 5; k++) begin
      a = int'(rt[k*3 +: 3]);
      b = int'(rt[((k + 1) % 5)*3 +: 3]);
      cyc += 1;
      if (a >= 5) begin e = 1'b1; break; end
      cyc += 1;
      if (b >= 5) begin e = 1'b1; break; end
      dx = int'(cx[a]) - int'(cx[b]);
      dy = int'(cy[a]) - int'(cy[b]);
      len += isqrt(dx * dx + dy * dy);
      cyc += 3 + isqrt(dx * dx + dy * dy);
    end
    cyc += 1;
    if (e) len = 4095;
  endtask

  task automatic run(input logic [14:0] rt, input int exp_len, input bit exp_err,
                     input int exp_cyc, input bit disturb, input bit chk7, input string nm);
    int cnt, busy_cnt, dcount;
    bit seen7, bad7;
    logic [11:0] held;
    busy_cnt = 0; seen7 = 0; bad7 = 0;
    @(negedge clk);
    route = rt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    while (done !== 1'b1 && cnt < 3000) begin
      if (busy) busy_cnt++;
      if (seen7 && coord_addr == 3'd7) bad7 = 1'b1;
      if (coord_addr == 3'd7) seen7 = 1'b1;
      if (disturb && cnt == 5) begin
        start = 1'b1;
        route = ~rt;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
    chk({nm, "_done_seen"}, int'(done), 1);
    chk({nm, "_done_cycle"}, cnt, exp_cyc);
    chk({nm, "_busy_cycles"}, busy_cnt, exp_cyc - 1);
    chk({nm, "_tour_len"}, int'(tour_len), exp_len);
    chk({nm, "_err"}, int'(err), int'(exp_err));
    chk({nm, "_busy_in_done"}, int'(busy), 1);
    chk({nm, "_addr_in_done"}, int'(coord_addr), 0);
    if (chk7) begin
      chk({nm, "_addr7_seen"}, int'(seen7), 1);
      chk({nm, "_addr7_after_flag"}, int'(bad7), 0);
    end
    held = tour_len;
    @(negedge clk);
    chk({nm, "_done_pulse_len"}, int'(done), 0);
    chk({nm, "_busy_after"}, int'(busy), 0);
    chk({nm, "_len_hold"}, int'(tour_len), int'(held));
    if (disturb) begin
      dcount = 0;
      repeat (60) begin
        @(negedge clk);
        if (done) dcount++;
      end
      chk({nm, "_extra_done"}, dcount, 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mlen, mcyc, cnt;
    bit merr;
    logic [14:0] rt;
    logic [63:0] xs, ys;

    tbl[0] = '{pk(10, 10, 10, 10, 10), pk(10, 10, 10, 10, 10), mk_rt(0, 1, 2, 3, 4),
               0, 1'b0, 26, 1'b0, "same_point"};
    tbl[1] = '{pk(0, 3, 6, 6, 3), pk(0, 4, 8, 4, 0), mk_rt(0, 1, 2, 3, 4),
               22, 1'b0, 48, 1'b0, "pentagon"};
    tbl[2] = '{pk(0, 255, 0, 0, 0), pk(0, 255, 0, 0, 0), mk_rt(0, 1, 0, 1, 0),
               1440, 1'b0, 1466, 1'b0, "max_diag"};
    tbl[3] = '{pk(0, 1, 0, 0, 0), pk(0, 1, 0, 0, 0), mk_rt(0, 1, 1, 1, 1),
               2, 1'b0, 28, 1'b0, "unit_diag"};
    tbl[4] = '{pk(0, 3, 6, 6, 3), pk(0, 4, 8, 4, 0), mk_rt(0, 1, 7, 3, 4),
               4095, 1'b1, 13, 1'b1, "bad_index"};

    set_coords(tbl[0].xs, tbl[0].ys);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_len", int'(tour_len), 0);
    chk("reset_addr", int'(coord_addr), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      set_coords(tbl[i].xs, tbl[i].ys);
      run(tbl[i].rt, tbl[i].len, tbl[i].e, tbl[i].cyc, 1'b0, tbl[i].chk7, tbl[i].nm);
    end

    // Abort during ROOT of leg 2 (cycles 24..28 after the start edge).
    set_coords(tbl[1].xs, tbl[1].ys);
    run(tbl[1].rt, 22, 1'b0, 48, 1'b0, 1'b0, "pre_abort");
    @(negedge clk);
    route = tbl[1].rt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    while (cnt < 25) begin
      @(negedge clk);
      cnt++;
    end
    chk("abort_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_len", int'(tour_len), 0);
    chk("abort_addr", int'(coord_addr), 0);
    @(negedge clk);
    chk("abort_held_busy", int'(busy), 0);
    rst_n = 1'b1;
    run(tbl[1].rt, 22, 1'b0, 48, 1'b0, 1'b0, "after_abort");

    run(tbl[1].rt, 22, 1'b0, 48, 1'b1, 1'b0, "disturbed");

    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 8; i++) begin
        xs[i*8 +: 8] = 8'($urandom_range(0, 255));
        ys[i*8 +: 8] = 8'($urandom_range(0, 255));
      end
      set_coords(xs, ys);
      for (int k = 0; k < 5; k++) begin
        if ($urandom_range(0, 19) == 0) rt[k*3 +: 3] = 3'($urandom_range(5, 7));
        else rt[k*3 +: 3] = 3'($urandom_range(0, 4));
      end
      model(rt, mlen, merr, mcyc);
      run(rt, mlen, merr, mcyc, 1'b0, 1'b0, $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
